temp_avg_mc: RTL

Multi-channel temperature smoothing filter placed between the I2C temperature reader and the 7-segment/display formatting logic. It accepts one signed fixed-point sample at a time, tagged with a channel number. For each channel it produces either a power-of-two boxcar moving average or a first-order IIR (exponential) average. The first sample on a channel seeds that channel's filter state, so the output starts at the first reading rather than ramping up from zero.

---
 rtl/temp_avg_mc.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/temp_avg_mc.sv
// Multi-channel temperature smoothing filter: per-channel power-of-two boxcar
// or first-order IIR average of signed samples, seeded by each channel's first reading.
module temp_avg_mc #(
    parameter  int NUM_CH     = 2,
    parameter  int SMPL_W     = 16,
    parameter  int DEPTH_LOG2 = 4,
    parameter  int IIR_SHIFT  = 3,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [SMPL_W-1:0] in_data,
    input  logic              mode,
    input  logic              clear,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [SMPL_W-1:0] out_data,
    output logic              out_full
);

    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int FILL_W    = DEPTH_LOG2 + 1;
    localparam int PTR_W     = DEPTH_LOG2;
    localparam int SUM_W     = SMPL_W + DEPTH_LOG2;
    localparam int ACC_W     = SMPL_W + IIR_SHIFT;
    localparam int ADDR_W    = CH_W + DEPTH_LOG2;
    localparam int RAM_DEPTH = NUM_CH * DEPTH;

    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(DEPTH);
    localparam logic signed [SUM_W:0]   BOX_HALF  = (SUM_W + 1)'(1 << (DEPTH_LOG2 - 1));
    localparam logic signed [ACC_W:0]   IIR_HALF  = (ACC_W + 1)'(1 << (IIR_SHIFT - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]          ch_q;
    logic signed [SMPL_W-1:0] data_q;
    logic                     mode_q;
    logic                     accept;
    logic                     ch_ok;

    // Per-channel filter state
    logic [NUM_CH-1:0]             seeded_q, seeded_d;
    logic [NUM_CH-1:0][FILL_W-1:0] fill_q,   fill_d;
    logic [NUM_CH-1:0][PTR_W-1:0]  ptr_q,    ptr_d;
    logic [NUM_CH-1:0][SMPL_W-1:0] seed_q,   seed_d;
    logic [NUM_CH-1:0][SUM_W-1:0]  sum_q,    sum_d;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc_q,    acc_d;

    logic [SMPL_W-1:0] mem_q [RAM_DEPTH];
    logic [SMPL_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    logic [SMPL_W-1:0] res_data_q;
    logic              res_full_q;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [SMPL_W-1:0] out_data_q;
    logic              out_full_q;

    // Datapath for the sample being processed in CALC
    logic                     seeded_cur;
    logic [FILL_W-1:0]        fill_cur, fill_new;
    logic [PTR_W-1:0]         ptr_cur;
    logic signed [SMPL_W-1:0] old_smpl;
    logic signed [SUM_W-1:0]  sum_cur, x_sum, old_sum, sum_new;
    logic signed [ACC_W-1:0]  acc_cur, x_acc, acc_new;
    logic signed [ACC_W:0]    iir_diff, iir_rnd;
    logic signed [SUM_W:0]    box_rnd;
    logic signed [SMPL_W-1:0] box_avg, iir_avg, calc_data;
    logic                     calc_full;

    if ((1 << CH_W) == NUM_CH) begin : g_ch_pow2
        assign ch_ok = 1'b1;
    end else begin : g_ch_npow2
        localparam logic [CH_W-1:0] CH_LIMIT = CH_W'(NUM_CH);
        assign ch_ok = (ch_q < CH_LIMIT);
    end

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_ready && in_valid && !clear;
    assign ram_addr = {ch_q, ptr_q[ch_q]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_READ;
            S_READ:  state_d = ch_ok ? S_CALC : S_IDLE;
            S_CALC:  state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    always_comb begin
        seeded_cur = seeded_q[ch_q];
        fill_cur   = fill_q[ch_q];
        ptr_cur    = ptr_q[ch_q];
        sum_cur    = sum_q[ch_q];
        acc_cur    = acc_q[ch_q];
        // Until the window holds real samples the seed stands in for the missing ones.
        old_smpl   = (fill_cur < FILL_FULL) ? seed_q[ch_q] : rd_data_q;
        x_sum      = SUM_W'(data_q);
        old_sum    = SUM_W'(old_smpl);
        x_acc      = ACC_W'(data_q) <<< IIR_SHIFT;
        iir_diff   = (ACC_W + 1)'(x_acc) - (ACC_W + 1)'(acc_cur);

        if (seeded_cur) begin
            sum_new  = sum_cur + x_sum - old_sum;
            fill_new = (fill_cur < FILL_FULL) ? fill_cur + FILL_W'(1) : fill_cur;
            acc_new  = acc_cur + ACC_W'(iir_diff >>> IIR_SHIFT);
        end else begin
            sum_new  = x_sum <<< DEPTH_LOG2;
            fill_new = FILL_W'(1);
            acc_new  = x_acc;
        end

        box_rnd   = (SUM_W + 1)'(sum_new) + BOX_HALF;
        iir_rnd   = (ACC_W + 1)'(acc_new) + IIR_HALF;
        box_avg   = SMPL_W'(box_rnd >>> DEPTH_LOG2);
        iir_avg   = SMPL_W'(iir_rnd >>> IIR_SHIFT);
        calc_data = !seeded_cur ? data_q : (mode ? iir_avg : box_avg);
        calc_full = mode || (fill_new == FILL_FULL);
    end

    // NOTE: every variable below gets its default before any branch, so no latch is inferred.
    always_comb begin
        seeded_d = seeded_q;
        fill_d   = fill_q;
        ptr_d    = ptr_q;
        seed_d   = seed_q;
        sum_d    = sum_q;
        acc_d    = acc_q;
        ram_we   = 1'b0;
        if (clear) begin
            seeded_d = '0;
            fill_d   = '0;
            ptr_d    = '0;
        end else begin
            if (state_q == S_CALC) begin
                seeded_d[ch_q] = 1'b1;
                fill_d[ch_q]   = fill_new;
                ptr_d[ch_q]    = ptr_cur + PTR_W'(1);
                sum_d[ch_q]    = sum_new;
                acc_d[ch_q]    = acc_new;
                if (!seeded_cur) seed_d[ch_q] = data_q;
                ram_we         = 1'b1;
            end
            // A mode switch forces every channel to re-seed from its next sample.
            if (mode != mode_q) seeded_d = '0;
        end
    end

    // NOTE: the history RAM is deliberately not reset; fill/seed logic never reads stale entries.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_addr] <= data_q;
        if ((state_q == S_READ) && ch_ok) rd_data_q <= mem_q[ram_addr];
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            seeded_q    <= '0;
            fill_q      <= '0;
            ptr_q       <= '0;
            seed_q      <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode;
            seeded_q <= seeded_d;
            fill_q   <= fill_d;
            ptr_q    <= ptr_d;
            seed_q   <= seed_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            if (accept) begin
                ch_q   <= in_ch;
                data_q <= in_data;
            end
            if (state_q == S_CALC) begin
                res_data_q <= calc_data;
                res_full_q <= calc_full;
            end
            out_valid_q <= (state_q == S_OUT) && !clear;
            if ((state_q == S_OUT) && !clear) begin
                out_ch_q   <= ch_q;
                out_data_q <= res_data_q;
                out_full_q <= res_full_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;

endmodule
